multicycle_cu: RTL and testbench

MULTICYCLE_CU -- requirements
Module: multicycle_cu

---
 rtl/multicycle_cu.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// multicycle_cu: control unit for a multi-cycle RV32 subset datapath
// (lw, sw, R-type ALU, I-type ALU, beq, jal) sharing one unified memory.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; forces FETCH, masks strobes
//   instr      instruction register contents (valid from DECODE onward)
//   zero       ALU result equals zero (branch condition)
//   mem_ready  memory completes the current access this cycle
//   pc_write   PC load enable
//   adr_src    memory address select (0 = PC, 1 = ALU result)
//   ir_write   instruction register load enable
//   mem_write  memory write strobe
//   reg_write  register file write strobe
//   illegal    one-cycle pulse in DECODE for an unrecognised opcode
//   result_src result mux select (00 ALUOut, 01 mem data, 10 ALU result)
//   alu_src_a  ALU A select (00 PC, 01 oldPC, 10 rs1)
//   alu_src_b  ALU B select (00 rs2, 01 imm, 10 const 4)
//   imm_src    immediate format select
//   alu_ctrl   ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   state      current FSM state (debug)
module multicycle_cu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             illegal,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_ctrl,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_lw, is_sw, is_r, is_i, is_beq, is_jal, is_known;

  logic       pc_update, branch, ir_wr;
  logic [1:0] alu_op;

  // Only opcode, funct3 and bit 30 steer control.
  logic       unused_instr_bits;
  assign unused_instr_bits = ^{instr[WIDTH-1:31], instr[29:15], instr[11:7]};

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_jal   = (opcode == OP_JAL);
  assign is_known = is_lw | is_sw | is_r | is_i | is_beq | is_jal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_r)      state_d = S_EXECUTER;
        else if (is_i)      state_d = S_EXECUTEI;
        else if (is_beq)    state_d = S_BEQ;
        else if (is_jal)    state_d = S_JAL;
        else                state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (is_lw)      state_d = S_MEMREAD;
        else if (is_sw) state_d = S_MEMWRITE;
        else            state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore decode of the state register; FETCH is the only state whose
  // strobes also follow mem_ready, so a stall holds everything else steady.
  always_comb begin
    adr_src    = 1'b0;
    ir_wr      = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_wr      = mem_ready;
        pc_update  = mem_ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // FETCH strobes depend on mem_ready, so they are masked by rst directly
  // rather than relying on the state register alone.
  assign ir_write = ir_wr & ~rst;
  assign pc_write = (pc_update | (branch & zero)) & ~rst;
  assign illegal  = (state_q == S_DECODE) & ~is_known;
  assign state    = state_q;

  always_comb begin
    imm_src = 2'b00;
    if (is_sw)       imm_src = 2'b01;
    else if (is_beq) imm_src = 2'b10;
    else if (is_jal) imm_src = 2'b11;
  end

  // Subtract only for R-type (opcode[5]=1); addi with bit 30 set stays add.
  always_comb begin
    alu_ctrl = 3'b000;
    case (alu_op)
      2'b01: alu_ctrl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctrl = (opcode[5] & instr[30]) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b000;
        endcase
      end
      default: alu_ctrl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_cu.sv
module tb_multicycle_cu;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;

  multicycle_cu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .alu_ctrl   (alu_ctrl),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADDI = 32'h40000093; // addi x1,x0,0x400 (bit 30 set)
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_SLL  = 32'h002091B3;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_ILL  = 32'h00000000;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic        pcw, irw, memw, regw, ill;
    logic [2:0]  aluc;
    logic [1:0]  imm;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic r(input logic [31:0] i, input logic z, input logic rd, input logic [3:0] st,
                   input logic pcw, input logic irw, input logic memw, input logic regw,
                   input logic ill, input logic [2:0] aluc, input logic [1:0] imm);
    vec_t v;
    v.instr = i; v.zero = z; v.rdy = rd; v.st = st;
    v.pcw = pcw; v.irw = irw; v.memw = memw; v.regw = regw; v.ill = ill;
    v.aluc = aluc; v.imm = imm;
    tbl.push_back(v);
  endtask

  // FETCH, DECODE, EXECUTE(R/I), ALUWB with no stalls
  task automatic alu_instr(input logic [31:0] i, input logic [3:0] ex, input logic [2:0] aluc);
    r(i, 0, 1, 4'd0, 1, 1, 0, 0, 0, 3'b000, 2'b00);
    r(i, 0, 1, 4'd1, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(i, 0, 1, ex,   0, 0, 0, 0, 0, aluc,   2'b00);
    r(i, 0, 1, 4'd8, 0, 0, 0, 1, 0, 3'b000, 2'b00);
  endtask

  // {adr_src, result_src, alu_src_a, alu_src_b} expected for each state
  function automatic logic [6:0] exp_mux(input logic [3:0] s);
    case (s)
      4'd0:    return 7'b0_10_00_10;
      4'd1:    return 7'b0_00_01_01;
      4'd2:    return 7'b0_00_10_01;
      4'd3:    return 7'b1_00_00_00;
      4'd4:    return 7'b0_01_00_00;
      4'd5:    return 7'b1_00_00_00;
      4'd6:    return 7'b0_00_10_00;
      4'd7:    return 7'b0_00_10_01;
      4'd8:    return 7'b0_00_00_00;
      4'd9:    return 7'b0_00_10_00;
      4'd10:   return 7'b0_00_01_10;
      default: return 7'b0_10_00_10;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- vector table ----------------
    alu_instr(I_ADD,  4'd6, 3'b000);
    alu_instr(I_SUB,  4'd6, 3'b001);
    alu_instr(I_ADDI, 4'd7, 3'b000);
    alu_instr(I_OR,   4'd6, 3'b011);
    alu_instr(I_AND,  4'd6, 3'b010);
    alu_instr(I_SLT,  4'd6, 3'b101);
    alu_instr(I_SLL,  4'd6, 3'b000);
    // lw: two fetch stall cycles, three MEMREAD stall cycles
    r(I_LW, 0, 0, 4'd0, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 0, 4'd0, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 1, 4'd0, 1, 1, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 1, 4'd1, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 1, 4'd2, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 0, 4'd3, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 0, 4'd3, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 0, 4'd3, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 1, 4'd3, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 1, 4'd4, 0, 0, 0, 1, 0, 3'b000, 2'b00);
    // lw without stalls: 5 cycles
    r(I_LW, 0, 1, 4'd0, 1, 1, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 1, 4'd1, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 1, 4'd2, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 1, 4'd3, 0, 0, 0, 0, 0, 3'b000, 2'b00);
    r(I_LW, 0, 1, 4'd4, 0, 0, 0, 1, 0, 3'b000, 2'b00);
    // sw: MEMWRITE stalled two cycles, mem_write held
    r(I_SW, 0, 1, 4'd0, 1, 1, 0, 0, 0, 3'b000, 2'b01);
    r(I_SW, 0, 1, 4'd1, 0, 0, 0, 0, 0, 3'b000, 2'b01);
    r(I_SW, 0, 1, 4'd2, 0, 0, 0, 0, 0, 3'b000, 2'b01);
    r(I_SW, 0, 0, 4'd5, 0, 0, 1, 0, 0, 3'b000, 2'b01);
    r(I_SW, 0, 0, 4'd5, 0, 0, 1, 0, 0, 3'b000, 2'b01);
    r(I_SW, 0, 1, 4'd5, 0, 0, 1, 0, 0, 3'b000, 2'b01);
    // beq taken
    r(I_BEQ, 1, 1, 4'd0, 1, 1, 0, 0, 0, 3'b000, 2'b10);
    r(I_BEQ, 1, 1, 4'd1, 0, 0, 0, 0, 0, 3'b000, 2'b10);
    r(I_BEQ, 1, 1, 4'd9, 1, 0, 0, 0, 0, 3'b001, 2'b10);
    // beq not taken; zero=1 while stalled in FETCH must not write PC
    r(I_BEQ, 1, 0, 4'd0, 0, 0, 0, 0, 0, 3'b000, 2'b10);
    r(I_BEQ, 0, 1, 4'd0, 1, 1, 0, 0, 0, 3'b000, 2'b10);
    r(I_BEQ, 0, 1, 4'd1, 0, 0, 0, 0, 0, 3'b000, 2'b10);
    r(I_BEQ, 0, 1, 4'd9, 0, 0, 0, 0, 0, 3'b001, 2'b10);
    // jal
    r(I_JAL, 0, 1, 4'd0,  1, 1, 0, 0, 0, 3'b000, 2'b11);
    r(I_JAL, 0, 1, 4'd1,  0, 0, 0, 0, 0, 3'b000, 2'b11);
    r(I_JAL, 0, 1, 4'd10, 1, 0, 0, 0, 0, 3'b000, 2'b11);
    r(I_JAL, 0, 1, 4'd8,  0, 0, 0, 1, 0, 3'b000, 2'b11);
    // unrecognised opcode: one illegal pulse, then FETCH
    r(I_ILL, 0, 1, 4'd0, 1, 1, 0, 0, 0, 3'b000, 2'b00);
    r(I_ILL, 0, 1, 4'd1, 0, 0, 0, 0, 1, 3'b000, 2'b00);
    r(I_ILL, 0, 0, 4'd0, 0, 0, 0, 0, 0, 3'b000, 2'b00);

    // ---------------- reset state ----------------
    rst = 1'b1; instr = I_ADD; zero = 1'b1; mem_ready = 1'b1;
    #2;
    chk("rst.state", state, 4'd0);
    chk("rst.strobes", {pc_write, ir_write, mem_write, reg_write, illegal}, 5'b0);
    chk("rst.mux", {adr_src, result_src, alu_src_a, alu_src_b}, exp_mux(4'd0));
    chk("rst.alu_ctrl", alu_ctrl, 3'b000);
    @(posedge clk); #1;
    chk("rst.hold", state, 4'd0);
    rst = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      instr = tbl[i].instr; zero = tbl[i].zero; mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d.state", i), state, tbl[i].st);
      chk($sformatf("row%0d.pc_write", i), pc_write, tbl[i].pcw);
      chk($sformatf("row%0d.ir_write", i), ir_write, tbl[i].irw);
      chk($sformatf("row%0d.mem_write", i), mem_write, tbl[i].memw);
      chk($sformatf("row%0d.reg_write", i), reg_write, tbl[i].regw);
      chk($sformatf("row%0d.illegal", i), illegal, tbl[i].ill);
      chk($sformatf("row%0d.alu_ctrl", i), alu_ctrl, tbl[i].aluc);
      chk($sformatf("row%0d.imm_src", i), imm_src, tbl[i].imm);
      chk($sformatf("row%0d.mux", i), {adr_src, result_src, alu_src_a, alu_src_b},
          exp_mux(tbl[i].st));
      @(posedge clk); #1;
    end

    // ---------------- async reset inside MEMWRITE ----------------
    instr = I_SW; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    chk("mw.state", state, 4'd5);
    chk("mw.mem_write", mem_write, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mw.rst_state", state, 4'd0);
    chk("mw.rst_mem_write", mem_write, 1'b0);
    mem_ready = 1'b1;
    #1;
    chk("mw.rst_strobes", {pc_write, ir_write, reg_write, illegal}, 4'b0);
    @(posedge clk); #1;
    chk("mw.rst_held", state, 4'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mw.first_fetch", state, 4'd1);

    // ---------------- async reset inside MEMREAD: no MEMWB afterwards ----------------
    instr = I_LW;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("mr.state", state, 4'd3);
    rst = 1'b1;
    #1;
    chk("mr.rst_state", state, 4'd0);
    #2 rst = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("mr.after_state", state, 4'd1);
    chk("mr.after_reg_write", reg_write, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
